vga_display: RTL and testbench

VGA_DISPLAY -- requirements
Module: vga_display

---
 rtl/vga_display.sv | 124 ++++++++++++
 tb/tb_vga_display.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_display.sv
// 640x480 VGA timing generator that scales a 160x120 8-bit greyscale framebuffer up 4x by 4x.
// The framebuffer read is registered, so the sync, enable and first-pixel flags travel through a matching pipeline.
module vga_display #(
    parameter int ADDR_WIDTH = 15,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic                  pclk,
    input  logic                  reset_n,
    input  logic [7:0]            data_in,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [7:0]            Y,
    output logic                  frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_WIDTH-1:0] SRC_WIDTH = ADDR_WIDTH'(H_ACTIVE / 4);

    // Pipeline flag layout: {active, hsync_raw, vsync_raw, first}; idle has both syncs deasserted (high).
    localparam int P_ACT   = 3;
    localparam int P_HS    = 2;
    localparam int P_VS    = 1;
    localparam int P_FIRST = 0;
    localparam logic [3:0] PIPE_IDLE = 4'b0110;

    logic [HW-1:0]         h_cnt_q, h_cnt_d;
    logic [VW-1:0]         v_cnt_q, v_cnt_d;
    logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
    logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
    logic                  h_wrap, v_wrap;
    logic [3:0]            stage0;
    logic [3:0]            stage1_q, stage2_q;
    logic                  hsync_q, vsync_q, de_q, frame_start_q;
    logic [7:0]            y_q;

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        v_wrap  = (v_cnt_q == V_LAST);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);

        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
        end

        // Each source row spans four display lines; step to the next row after the fourth.
        line_base_d = line_base_q;
        if (h_wrap) begin
            if (v_wrap) begin
                line_base_d = '0;
            end else if ((v_cnt_q[1:0] == 2'b11) && (v_cnt_q < V_ACT_END)) begin
                line_base_d = line_base_q + SRC_WIDTH;
            end
        end

        stage0          = PIPE_IDLE;
        stage0[P_ACT]   = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
        stage0[P_HS]    = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
        stage0[P_VS]    = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
        stage0[P_FIRST] = (h_cnt_q == '0) && (v_cnt_q == '0);

        read_addr_d = read_addr_q;
        if (stage0[P_ACT]) begin
            read_addr_d = line_base_q + ADDR_WIDTH'(h_cnt_q >> 2);
        end
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            line_base_q   <= '0;
            read_addr_q   <= '0;
            stage1_q      <= PIPE_IDLE;
            stage2_q      <= PIPE_IDLE;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            y_q           <= 8'h00;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_base_q   <= line_base_d;
            read_addr_q   <= read_addr_d;
            stage1_q      <= stage0;
            stage2_q      <= stage1_q;
            // data_in for a pixel arrives exactly as its flags leave stage 2.
            hsync_q       <= stage2_q[P_HS];
            vsync_q       <= stage2_q[P_VS];
            de_q          <= stage2_q[P_ACT];
            y_q           <= stage2_q[P_ACT] ? data_in : 8'h00;
            frame_start_q <= stage2_q[P_FIRST];
        end
    end

    assign read_addr   = read_addr_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign Y           = y_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_display.sv
// Directed bench for vga_display on a reduced raster (48x22 total, 32x16 active) so whole frames stay short.
module tb_vga_display;
    localparam int HA = 32, HF = 4, HS = 8, HB = 4;
    localparam int VA = 16, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [7:0] y;
        logic       fs;
    } exp_t;

    logic        pclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [14:0] read_addr;
    logic        hsync, vsync, de, frame_start;
    logic [7:0]  Y;

    int   vectors = 0;
    int   miscompares = 0;
    int   k = 0;
    int   exp_addr = 0;
    bit   ff_mode = 1'b0;
    exp_t exp_o;
    exp_t obs;

    vga_display #(
        .ADDR_WIDTH(15),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .pclk(pclk),
        .reset_n(reset_n),
        .data_in(data_in),
        .read_addr(read_addr),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .Y(Y),
        .frame_start(frame_start)
    );

    always #20 pclk = ~pclk;

    // Framebuffer model: one-cycle registered read holding addr[7:0], or a constant 0xFF.
    always @(posedge pclk) data_in <= ff_mode ? 8'hFF : read_addr[7:0];

    function automatic bit is_active(int pos);
        if (pos < 0) return 1'b0;
        return ((pos % HT) < HA) && (((pos / HT) % VT) < VA);
    endfunction

    function automatic int src_addr(int pos);
        int h, v;
        h = pos % HT;
        v = (pos / HT) % VT;
        return (v / 4) * (HA / 4) + h / 4;
    endfunction

    function automatic exp_t model(int pos, bit ff);
        exp_t e;
        int h, v;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (pos >= 0) begin
            h = pos % HT;
            v = (pos / HT) % VT;
            e.de = (h < HA) && (v < VA);
            e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
            e.vs = !((v >= VA + VF) && (v < VA + VF + VS));
            e.fs = (h == 0) && (v == 0);
            if (e.de) e.y = ff ? 8'hFF : 8'(src_addr(pos));
        end
        return e;
    endfunction

    // Advance one clock; k counts edges since release, outputs lag the counter by 3.
    task automatic step();
        @(negedge pclk);
        k++;
        if (is_active(k - 1)) exp_addr = src_addr(k - 1);
        exp_o = model(k - 3, ff_mode);
        obs = {hsync, vsync, de, Y, frame_start};
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge pclk);
        vectors++; if (hsync !== 1'b1) begin miscompares++; $display("FAIL reset_hsync: got %b want 1", hsync); end
        vectors++; if (vsync !== 1'b1) begin miscompares++; $display("FAIL reset_vsync: got %b want 1", vsync); end
        vectors++; if (de !== 1'b0) begin miscompares++; $display("FAIL reset_de: got %b want 0", de); end
        vectors++; if (Y !== 8'h00) begin miscompares++; $display("FAIL reset_y: got %h want 00", Y); end
        vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_fs: got %b want 0", frame_start); end
        vectors++; if (read_addr !== 15'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", read_addr); end
        $display("test_reset: outputs checked while reset_n low");
    endtask

    task automatic test_frames();
        int   hs_fall = -1, vs_fall = -1, de_fall = -1;
        int   hs_low = 0, vs_low = 0, de_run = 0, de_lines = 0;
        int   fs_seen = 0, max_addr = 0, h1, v1;
        logic hs_p = 1'b1, vs_p = 1'b1, de_p = 1'b0;
        ff_mode = 1'b0;
        reset_n = 1'b1;
        k = 0;
        exp_addr = 0;
        repeat (2 * FRAME) begin
            step();
            vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL stream k=%0d: got %h want %h", k, obs, exp_o); end
            vectors++; if (read_addr !== 15'(exp_addr)) begin miscompares++; $display("FAIL addr k=%0d: got %0d want %0d", k, read_addr, exp_addr); end
            h1 = (k - 1) % HT;
            v1 = ((k - 1) / HT) % VT;
            if (h1 == 0 && v1 == 0) begin vectors++; if (read_addr !== 15'd0) begin miscompares++; $display("FAIL corner00: got %0d want 0", read_addr); end end
            if (h1 == HA - 1 && v1 == 0) begin vectors++; if (read_addr !== 15'(HA / 4 - 1)) begin miscompares++; $display("FAIL corner_row0_end: got %0d want %0d", read_addr, HA / 4 - 1); end end
            if (h1 == 0 && v1 == 4) begin vectors++; if (read_addr !== 15'(HA / 4)) begin miscompares++; $display("FAIL corner_row1: got %0d want %0d", read_addr, HA / 4); end end
            if (h1 == HA - 1 && v1 == VA - 1) begin vectors++; if (read_addr !== 15'((VA / 4) * (HA / 4) - 1)) begin miscompares++; $display("FAIL corner_last: got %0d want %0d", read_addr, (VA / 4) * (HA / 4) - 1); end end
            if (int'(read_addr) > max_addr) max_addr = int'(read_addr);
            if (hs_p && !hsync) begin
                if (hs_fall >= 0) begin vectors++; if (k - hs_fall != HT) begin miscompares++; $display("FAIL hsync_period: got %0d want %0d", k - hs_fall, HT); end end
                if (de_fall >= 0 && k - de_fall < HT) begin vectors++; if (k - de_fall != HF) begin miscompares++; $display("FAIL de_to_hsync: got %0d want %0d", k - de_fall, HF); end end
                hs_fall = k;
                hs_low = 0;
            end
            if (!hs_p && hsync) begin vectors++; if (hs_low != HS) begin miscompares++; $display("FAIL hsync_low: got %0d want %0d", hs_low, HS); end end
            if (!hsync) hs_low++;
            if (vs_p && !vsync) begin
                if (vs_fall >= 0) begin vectors++; if (k - vs_fall != FRAME) begin miscompares++; $display("FAIL vsync_period: got %0d want %0d", k - vs_fall, FRAME); end end
                vs_fall = k;
                vs_low = 0;
            end
            if (!vs_p && vsync) begin vectors++; if (vs_low != VS * HT) begin miscompares++; $display("FAIL vsync_low: got %0d want %0d", vs_low, VS * HT); end end
            if (!vsync) vs_low++;
            if (!de_p && de) de_run = 0;
            if (de) de_run++;
            if (de_p && !de) begin
                vectors++; if (de_run != HA) begin miscompares++; $display("FAIL de_run: got %0d want %0d", de_run, HA); end
                de_fall = k;
                de_lines++;
            end
            if (frame_start) begin
                fs_seen++;
                vectors++; if (!(de === 1'b1 && de_p === 1'b0)) begin miscompares++; $display("FAIL fs_align k=%0d: got de=%b prev=%b want 1/0", k, de, de_p); end
            end
            hs_p = hsync;
            vs_p = vsync;
            de_p = de;
        end
        vectors++; if (fs_seen != 2) begin miscompares++; $display("FAIL fs_count: got %0d want 2", fs_seen); end
        vectors++; if (de_lines != 2 * VA) begin miscompares++; $display("FAIL de_lines: got %0d want %0d", de_lines, 2 * VA); end
        vectors++; if (max_addr > (VA / 4) * (HA / 4) - 1) begin miscompares++; $display("FAIL max_addr: got %0d want <= %0d", max_addr, (VA / 4) * (HA / 4) - 1); end
        $display("test_frames: two frames streamed, max read_addr %0d", max_addr);
    endtask

    task automatic test_ff_data();
        ff_mode = 1'b1;
        repeat (FRAME) begin
            step();
            vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL ff_stream k=%0d: got %h want %h", k, obs, exp_o); end
            vectors++; if (Y !== (exp_o.de ? 8'hFF : 8'h00)) begin miscompares++; $display("FAIL ff_y k=%0d: got %h want %h", k, Y, exp_o.de ? 8'hFF : 8'h00); end
        end
        $display("test_ff_data: one frame with data_in held at FF");
    endtask

    task automatic test_midframe_reset();
        ff_mode = 1'b0;
        for (int i = 0; i < FRAME && (k % FRAME) != 10 * HT + 20; i++) begin
            step();
            vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL pre_reset k=%0d: got %h want %h", k, obs, exp_o); end
        end
        vectors++; if ((k % FRAME) != 10 * HT + 20) begin miscompares++; $display("FAIL reach_20_10: got %0d want %0d", k % FRAME, 10 * HT + 20); end
        reset_n = 1'b0;
        @(negedge pclk);
        vectors++; if (hsync !== 1'b1) begin miscompares++; $display("FAIL mid_hsync: got %b want 1", hsync); end
        vectors++; if (vsync !== 1'b1) begin miscompares++; $display("FAIL mid_vsync: got %b want 1", vsync); end
        vectors++; if (de !== 1'b0) begin miscompares++; $display("FAIL mid_de: got %b want 0", de); end
        vectors++; if (Y !== 8'h00) begin miscompares++; $display("FAIL mid_y: got %h want 00", Y); end
        vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL mid_fs: got %b want 0", frame_start); end
        vectors++; if (read_addr !== 15'd0) begin miscompares++; $display("FAIL mid_addr: got %0d want 0", read_addr); end
        reset_n = 1'b1;
        k = 0;
        exp_addr = 0;
        repeat (FRAME + 8) begin
            step();
            vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL post_reset k=%0d: got %h want %h", k, obs, exp_o); end
            vectors++; if (read_addr !== 15'(exp_addr)) begin miscompares++; $display("FAIL post_addr k=%0d: got %0d want %0d", k, read_addr, exp_addr); end
            if (k == 2 || k == 3 || k == FRAME + 3) begin
                vectors++; if (frame_start !== (k != 2)) begin miscompares++; $display("FAIL post_fs k=%0d: got %b want %b", k, frame_start, k != 2); end
            end
        end
        $display("test_midframe_reset: reset at (20,10), frame restarted from (0,0)");
    endtask

    initial begin
        test_reset();
        test_frames();
        test_ff_data();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
